// File: rtl/fft_pair_reader.sv
// Collects one FFT frame as butterfly pairs, stores each sample at its bit-reversed
// slot, then drains it one sample per cycle in natural bin order under out_ready backpressure.
module fft_pair_reader #(
   parameter int WORD_SIZE = 16,
   parameter int N_POINTS  = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WORD_SIZE-1:0]         in0_re,
   input  logic [WORD_SIZE-1:0]         in0_im,
   input  logic [WORD_SIZE-1:0]         in1_re,
   input  logic [WORD_SIZE-1:0]         in1_im,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WORD_SIZE-1:0]         out_re,
   output logic [WORD_SIZE-1:0]         out_im,
   output logic [$clog2(N_POINTS)-1:0]  out_idx,
   output logic                         out_last
);
   localparam int ADDR_W = $clog2(N_POINTS);
   localparam int PAIR_W = ADDR_W - 1;

   typedef enum logic {FILL, DRAIN} state_t;
   typedef struct packed {
      logic [WORD_SIZE-1:0] re;
      logic [WORD_SIZE-1:0] im;
   } sample_t;

   state_t              state, state_nxt;
   logic [PAIR_W-1:0]   wr_cnt;
   logic [ADDR_W-1:0]   rd_cnt;
   sample_t             mem [N_POINTS];
   logic [ADDR_W-1:0]   wr_addr0, wr_addr1;
   logic                accept, take, at_last;
   sample_t             rd_word;

   function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] r;
      for (int b = 0; b < ADDR_W; b++) r[b] = a[ADDR_W-1-b];
      return r;
   endfunction

   // Handshakes are gated by rst_n so nothing is accepted or consumed during reset.
   assign in_ready  = rst_n && (state == FILL);
   assign out_valid = rst_n && (state == DRAIN);
   assign accept    = in_valid && in_ready;
   assign take      = out_valid && out_ready;
   assign at_last   = (rd_cnt == ADDR_W'(N_POINTS - 1));

   assign wr_addr0 = bitrev({wr_cnt, 1'b0});
   assign wr_addr1 = bitrev({wr_cnt, 1'b1});
   assign rd_word  = mem[rd_cnt];

   assign out_re   = out_valid ? rd_word.re : '0;
   assign out_im   = out_valid ? rd_word.im : '0;
   assign out_idx  = out_valid ? rd_cnt : '0;
   assign out_last = out_valid && at_last;

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (accept && (wr_cnt == {PAIR_W{1'b1}})) state_nxt = DRAIN;
         DRAIN:   if (take && at_last) state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= FILL;
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         state <= state_nxt;
         // Both counters wrap to zero naturally on the final pair / final bin.
         if (accept) wr_cnt <= wr_cnt + PAIR_W'(1);
         if (take)   rd_cnt <= at_last ? '0 : rd_cnt + ADDR_W'(1);
      end
   end

   // Frame buffer has no reset; a stale frame is never read because rd_cnt restarts.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_addr0] <= '{re: in0_re, im: in0_im};
         mem[wr_addr1] <= '{re: in1_re, im: in1_im};
      end
   end
endmodule

// File: tb/tb_fft_pair_reader.sv
// Directed bench for fft_pair_reader: scoreboard of expected samples filled per frame,
// popped by a monitor on each output handshake.
module tb_fft_pair_reader;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_last;
   logic [15:0] in0_re, in0_im, in1_re, in1_im, out_re, out_im;
   logic [3:0]  out_idx;

   typedef struct {
      logic [3:0]  idx;
      logic [15:0] re;
      logic [15:0] im;
      logic        last;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          tests = 0;
   int          fails = 0;
   logic [15:0] p_re0[8], p_im0[8], p_re1[8], p_im1[8];

   fft_pair_reader #(.WORD_SIZE(16), .N_POINTS(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in0_re(in0_re), .in0_im(in0_im), .in1_re(in1_re), .in1_im(in1_im),
      .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re),
      .out_im(out_im), .out_idx(out_idx), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int brev4(input int x);
      int r = 0;
      for (int b = 0; b < 4; b++) if (((x >> b) & 1) != 0) r += (8 >> b);
      return r;
   endfunction

   // Drives p_* as 8 pairs; gap inserts an idle cycle between pairs. Expected
   // samples are queued once the frame is complete, in natural bin order.
   task automatic send_frame(input bit gap);
      logic [15:0] er[16], ei[16];
      int n;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         in0_re = p_re0[k]; in0_im = p_im0[k];
         in1_re = p_re1[k]; in1_im = p_im1[k];
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!in_ready && n < 50);
         if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         er[brev4(2*k)] = p_re0[k];   ei[brev4(2*k)] = p_im0[k];
         er[brev4(2*k+1)] = p_re1[k]; ei[brev4(2*k+1)] = p_im1[k];
         if (gap && k != 7) begin
            @(posedge clk); #1;
         end
      end
      for (int i = 0; i < 16; i++) sb.push_back('{idx: 4'(i), re: er[i], im: ei[i], last: (i == 15)});
   endtask

   task automatic wait_empty(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (n >= 200) chk({tag, "_drain_timeout"}, 32'(sb.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) chk("unexpected_out", {28'd0, out_idx}, 32'hFFFF_FFFF);
         else begin
            e = sb.pop_front();
            chk("out_idx", {28'd0, out_idx}, {28'd0, e.idx});
            chk("out_re", {16'd0, out_re}, {16'd0, e.re});
            chk("out_im", {16'd0, out_im}, {16'd0, e.im});
            chk("out_last", {31'd0, out_last}, {31'd0, e.last});
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in0_re = '0; in0_im = '0; in1_re = '0; in1_im = '0;

      // Reset held three cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_re", {16'd0, out_re}, 32'd0);
      chk("rst_out_idx", {28'd0, out_idx}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;

      // Ordering frame with backpressure at idx 3
      for (int k = 0; k < 8; k++) begin
         p_re0[k] = 16'(2*k);   p_im0[k] = 16'(-2*k);
         p_re1[k] = 16'(2*k+1); p_im1[k] = 16'(-(2*k+1));
      end
      send_frame(1'b0);
      @(negedge clk);
      chk("drain_out_valid", {31'd0, out_valid}, 32'd1);
      chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
      chk("drain_first_re", {16'd0, out_re}, 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_hold_idx", {28'd0, out_idx}, 32'd3);
         chk("bp_hold_re", {16'd0, out_re}, 32'd12);
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_empty("order");
      @(negedge clk);
      chk("post_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Gapped input, then in_valid held during drain
      for (int k = 0; k < 8; k++) begin
         p_re0[k] = 16'(16'h0100 + k); p_im0[k] = 16'(16'h0A00 + k);
         p_re1[k] = 16'(16'h0200 + k); p_im1[k] = 16'(16'h0B00 + k);
      end
      send_frame(1'b1);
      in_valid = 1'b1;
      in0_re = 16'hDEAD; in0_im = 16'hBEEF; in1_re = 16'hDEAD; in1_im = 16'hBEEF;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("drain_ignores_in", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_empty("gapped");
      #1 in_valid = 1'b0;
      @(posedge clk); #1;

      // Reset while idx 6 is presented
      for (int k = 0; k < 8; k++) begin
         p_re0[k] = 16'(16'h3000 + k); p_im0[k] = 16'(16'h3100 + k);
         p_re1[k] = 16'(16'h3200 + k); p_im1[k] = 16'(16'h3300 + k);
      end
      send_frame(1'b0);
      repeat (6) @(posedge clk);
      #1 chk("pre_rst_idx", {28'd0, out_idx}, 32'd6);
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("after_rst_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) begin
         p_re0[k] = 16'(16'h4000 + k); p_im0[k] = 16'(16'h4100 + k);
         p_re1[k] = 16'(16'h4200 + k); p_im1[k] = 16'(16'h4300 + k);
      end
      send_frame(1'b0);
      wait_empty("post_reset");

      // Three back-to-back frames with extreme values
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < 8; k++) begin
            p_re0[k] = 16'(16'h7FFF - k - f); p_im0[k] = 16'(16'h8000 + k);
            p_re1[k] = 16'(16'h8000 + f);     p_im1[k] = 16'(16'h7FFF - k);
         end
         send_frame(1'b0);
         wait_empty("b2b");
         @(negedge clk);
         chk("b2b_in_ready_rise", {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
      end

      chk("sb_empty_end", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
